// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 message padder.
package sha256_pkg;
  localparam int BLK_W         = 512;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 16;
  localparam int LEN_POS       = 14;
  localparam logic [7:0]        PAD_BYTE = 8'h80;
  localparam logic [WORD_W-1:0] PAD_WORD = {PAD_BYTE, 24'h000000};

  typedef enum logic [1:0] {
    ST_FILL       = 2'd0,
    ST_EMIT       = 2'd1,
    ST_PADBLK     = 2'd2,
    ST_EMIT_FINAL = 2'd3
  } state_e;
endpackage

// File: rtl/sha256_message_padder_if.sv
// Word-stream input and 512-bit block output of the SHA-256 padder.
interface sha256_message_padder_if;
  import sha256_pkg::*;

  // Both channels use valid/ready: a transfer happens on a rising clock edge where
  // valid and ready are both high; a raised valid holds its payload until that edge.
  logic              in_v_i;
  logic [WORD_W-1:0] in_data_i;
  logic [2:0]        in_bytes_i;
  logic              in_last_i;
  logic              in_ready_o;
  logic [BLK_W-1:0]  blk_o;
  logic              blk_v_o;
  logic              blk_last_o;
  logic              blk_ready_i;

  modport master (
    output in_v_i, in_data_i, in_bytes_i, in_last_i, blk_ready_i,
    input  in_ready_o, blk_o, blk_v_o, blk_last_o
  );

  modport slave (
    input  in_v_i, in_data_i, in_bytes_i, in_last_i, blk_ready_i,
    output in_ready_o, blk_o, blk_v_o, blk_last_o
  );
endinterface

// File: rtl/sha256_pad_word.sv
// Masks a final message word to its valid bytes and inserts the 0x80 pad byte after them.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] data_i,
  input  logic [2:0]        bytes_i,
  output logic [WORD_W-1:0] word_o,
  output logic              full_o
);

  always_comb begin
    word_o = '0;
    // A full word leaves no room, so the pad byte spills into the next word.
    full_o = (bytes_i >= 3'd4);
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < bytes_i) begin
        word_o[WORD_W-1-8*b -: 8] = data_i[WORD_W-1-8*b -: 8];
      end else if (3'(b) == bytes_i) begin
        word_o[WORD_W-1-8*b -: 8] = PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/sha256_message_padder.sv
// Packs 32-bit big-endian words into 512-bit SHA-256 blocks and appends FIPS 180-4 padding.
module sha256_message_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64,
  parameter int BLK_W = 512
) (
  input  logic   clk_i,
  input  logic   reset_n_i,
  sha256_message_padder_if.slave bus,
  output state_e state_o
);

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d, len_add;
  logic              pad_blk_q, pad_blk_d;
  logic              pad_pend_q, pad_pend_d;
  logic [WORD_W-1:0] wbuf_q [WORDS_PER_BLK];
  logic [WORD_W-1:0] wbuf_d [WORDS_PER_BLK];
  logic [WORD_W-1:0] pad_word;
  logic              pad_full;
  logic [4:0]        pad_pos;
  logic [63:0]       len_ins, len_cur;
  logic              acc;
  logic [BLK_W-1:0]  blk_d;

  sha256_pad_word u_pad_word (
    .data_i  (bus.in_data_i),
    .bytes_i (bus.in_bytes_i),
    .word_o  (pad_word),
    .full_o  (pad_full)
  );

  assign acc     = bus.in_v_i && (state_q == ST_FILL);
  assign pad_pos = {1'b0, idx_q} + {4'd0, pad_full};
  assign len_add = len_q + LEN_W'({bus.in_bytes_i, 3'b000});
  assign len_ins = 64'(len_add);
  assign len_cur = 64'(len_q);
  assign state_o = state_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_FILL;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (acc) begin
          if (!bus.in_last_i) begin
            if (idx_q == 4'd15) state_d = ST_EMIT;
          end else if (pad_pos < 5'(LEN_POS)) begin
            state_d = ST_EMIT_FINAL;
          end else begin
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT:       if (bus.blk_ready_i) state_d = pad_blk_q ? ST_PADBLK : ST_FILL;
      ST_PADBLK:     state_d = ST_EMIT_FINAL;
      ST_EMIT_FINAL: if (bus.blk_ready_i) state_d = ST_FILL;
      default:       state_d = ST_FILL;
    endcase
  end

  always_comb begin
    wbuf_d     = wbuf_q;
    idx_d      = idx_q;
    len_d      = len_q;
    pad_blk_d  = pad_blk_q;
    pad_pend_d = pad_pend_q;
    case (state_q)
      ST_FILL: begin
        if (acc) begin
          len_d = len_add;
          if (!bus.in_last_i) begin
            wbuf_d[idx_q] = bus.in_data_i;
            idx_d         = idx_q + 4'd1;
          end else begin
            idx_d      = '0;
            pad_blk_d  = (pad_pos >= 5'(LEN_POS));
            pad_pend_d = (pad_pos == 5'(WORDS_PER_BLK));
            for (int i = 0; i < WORDS_PER_BLK; i++) begin
              if (5'(i) == {1'b0, idx_q}) begin
                wbuf_d[i] = pad_word;
              end else if (5'(i) > {1'b0, idx_q}) begin
                wbuf_d[i] = (5'(i) == pad_pos) ? PAD_WORD : '0;
              end
            end
            // Length fits in this block only when the pad byte landed before word 14.
            if (pad_pos < 5'(LEN_POS)) begin
              wbuf_d[LEN_POS]   = len_ins[63:32];
              wbuf_d[LEN_POS+1] = len_ins[31:0];
            end
          end
        end
      end
      ST_PADBLK: begin
        for (int i = 0; i < WORDS_PER_BLK; i++) wbuf_d[i] = '0;
        wbuf_d[0]         = pad_pend_q ? PAD_WORD : '0;
        wbuf_d[LEN_POS]   = len_cur[63:32];
        wbuf_d[LEN_POS+1] = len_cur[31:0];
        pad_blk_d         = 1'b0;
        pad_pend_d        = 1'b0;
      end
      ST_EMIT_FINAL: begin
        if (bus.blk_ready_i) begin
          idx_d = '0;
          len_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      idx_q      <= '0;
      len_q      <= '0;
      pad_blk_q  <= 1'b0;
      pad_pend_q <= 1'b0;
      for (int i = 0; i < WORDS_PER_BLK; i++) wbuf_q[i] <= '0;
    end else begin
      idx_q      <= idx_d;
      len_q      <= len_d;
      pad_blk_q  <= pad_blk_d;
      pad_pend_q <= pad_pend_d;
      for (int i = 0; i < WORDS_PER_BLK; i++) wbuf_q[i] <= wbuf_d[i];
    end
  end

  always_comb begin
    blk_d = '0;
    for (int i = 0; i < WORDS_PER_BLK; i++) blk_d[BLK_W-1-WORD_W*i -: WORD_W] = wbuf_q[i];
    bus.blk_o      = blk_d;
    // Ready is gated by reset so every output reads 0 while reset is held.
    bus.in_ready_o = (state_q == ST_FILL) && reset_n_i;
    bus.blk_v_o    = (state_q == ST_EMIT) || (state_q == ST_EMIT_FINAL);
    bus.blk_last_o = (state_q == ST_EMIT_FINAL);
  end

endmodule
